// File: rtl/efuse_array_model.sv
`default_nettype none
// ============================================================================
// Module   : efuse_array_model
// Purpose  : Cycle-based NWORDS x WIDTH one-time-programmable eFuse array model
// Revision : 1.0
// ============================================================================
module efuse_array_model #(
    parameter int NWORDS      = 128,
    parameter int WIDTH       = 8,
    parameter int AW          = $clog2(NWORDS),
    parameter int BW          = $clog2(WIDTH),
    parameter int PGM_MIN_CYC = 4,
    parameter int READ_LAT    = 2,
    parameter logic [NWORDS*WIDTH-1:0] INIT_IMAGE = {NWORDS*WIDTH{1'b0}}
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 csb,
    input  logic                                 strobe,
    input  logic                                 load,
    input  logic                                 pgenb,
    input  logic                                 vddq,
    input  logic [BW+AW-1:0]                     a,
    output logic [WIDTH-1:0]                     q,
    output logic                                 q_valid,
    output logic                                 busy,
    output logic                                 pgm_err,
    output logic                                 rd_err,
    output logic [$clog2(NWORDS*WIDTH+1)-1:0]    blown_cnt
);
    localparam int c_BCW     = $clog2(NWORDS*WIDTH+1);
    localparam int c_CNT_MAX = (PGM_MIN_CYC > READ_LAT) ? PGM_MIN_CYC : READ_LAT;
    localparam int c_CW      = $clog2(c_CNT_MAX+1);

    localparam logic [c_CW-1:0] c_PGM_MIN = c_CW'(PGM_MIN_CYC);
    localparam logic [c_CW-1:0] c_RD_LAT  = c_CW'(READ_LAT);
    localparam logic [c_CW-1:0] c_CNT_SAT = c_CW'(c_CNT_MAX);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PGM  = 2'd1;
    localparam logic [1:0] c_ST_RD   = 2'd2;

    logic [1:0]       r_state;
    logic             r_strobe_d;
    logic [AW-1:0]    r_word;
    logic [BW-1:0]    r_bit;
    logic [c_CW-1:0]  r_cnt;
    logic [15:0]      r_lfsr;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_busy;
    logic             r_pgm_err;
    logic             r_rd_err;

    // Non-volatile state: initialised once, never touched by rst.
    logic [WIDTH-1:0] r_blown [NWORDS] = '{default: '0};
    logic [c_BCW-1:0] r_blown_cnt = '0;

    logic             w_rise;
    logic             w_mode_pgm;
    logic             w_mode_rd;
    logic             w_word_oob;
    logic             w_bit_oob;
    logic             w_pgm_ok;
    logic             w_blow;
    logic [15:0]      w_lfsr_next;
    logic [WIDTH-1:0] w_lfsr_q;
    logic [WIDTH-1:0] w_cur_word;
    logic [WIDTH-1:0] w_fuse [NWORDS];

    assign w_rise     = strobe && !r_strobe_d;
    assign w_mode_pgm = !csb && vddq && !pgenb && !load;
    assign w_mode_rd  = !csb && !vddq && pgenb && load;
    assign w_word_oob = (32'(r_word) >= NWORDS);
    assign w_bit_oob  = (32'(r_bit) >= WIDTH);
    assign w_pgm_ok   = (r_cnt >= c_PGM_MIN) && !w_word_oob && !w_bit_oob;
    assign w_blow     = !rst && (r_state == c_ST_PGM) && !strobe && w_pgm_ok;
    // x^16 + x^14 + x^13 + x^11, shifting right
    assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_cur_word  = w_word_oob ? '0 : w_fuse[r_word];

    generate
        for (genvar n = 0; n < NWORDS; n++) begin : g_words
            assign w_fuse[n] = INIT_IMAGE[n*WIDTH +: WIDTH] | r_blown[n];
        end
        if (WIDTH <= 16) begin : g_lfsr_narrow
            assign w_lfsr_q = r_lfsr[WIDTH-1:0];
        end else begin : g_lfsr_wide
            assign w_lfsr_q = {{(WIDTH-16){1'b0}}, r_lfsr};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_blow) begin
            r_blown[r_word][r_bit] <= 1'b1;
            if (!w_cur_word[r_bit]) begin
                r_blown_cnt <= r_blown_cnt + c_BCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_strobe_d <= 1'b0;
            r_word     <= '0;
            r_bit      <= '0;
            r_cnt      <= '0;
            r_lfsr     <= 16'hACE1;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_busy     <= 1'b0;
            r_pgm_err  <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_strobe_d <= strobe;
            r_q_valid  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rise) begin
                        if (w_mode_pgm || w_mode_rd) begin
                            r_word  <= a[AW-1:0];
                            r_bit   <= a[BW+AW-1:AW];
                            // The rising-edge cycle is the first counted cycle.
                            r_cnt   <= c_CNT_ONE;
                            r_busy  <= 1'b1;
                            r_state <= w_mode_pgm ? c_ST_PGM : c_ST_RD;
                        end else begin
                            r_q      <= w_lfsr_q;
                            r_lfsr   <= w_lfsr_next;
                            r_rd_err <= 1'b1;
                        end
                    end
                end
                c_ST_PGM: begin
                    if (!strobe) begin
                        if (!w_pgm_ok) begin
                            r_pgm_err <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else if (!w_mode_pgm) begin
                        r_pgm_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end else if (r_cnt != c_CNT_SAT) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_RD: begin
                    if (r_cnt >= c_RD_LAT) begin
                        r_q       <= w_cur_word;
                        r_q_valid <= 1'b1;
                        if (w_word_oob) begin
                            r_rd_err <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign busy      = r_busy;
    assign pgm_err   = r_pgm_err;
    assign rd_err    = r_rd_err;
    assign blown_cnt = r_blown_cnt;

endmodule
`default_nettype wire

// File: tb/tb_efuse_array_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_efuse_array_model
// Purpose  : Directed self-checking bench for efuse_array_model
// Revision : 1.0
// ============================================================================
module tb_efuse_array_model;
    localparam int NW   = 100;
    localparam int W    = 8;
    localparam int PMIN = 4;
    localparam int RL   = 2;
    localparam int BCW  = $clog2(NW*W+1);
    localparam logic [NW*W-1:0] IMG = (800'hA5 << 40) | 800'h10;

    logic           clk;
    logic           rst;
    logic           csb;
    logic           strobe;
    logic           load;
    logic           pgenb;
    logic           vddq;
    logic [9:0]     a;
    logic [W-1:0]   q;
    logic           q_valid;
    logic           busy;
    logic           pgm_err;
    logic           rd_err;
    logic [BCW-1:0] blown_cnt;

    efuse_array_model #(
        .NWORDS(NW), .WIDTH(W), .PGM_MIN_CYC(PMIN), .READ_LAT(RL), .INIT_IMAGE(IMG)
    ) dut (
        .clk(clk), .rst(rst), .csb(csb), .strobe(strobe), .load(load),
        .pgenb(pgenb), .vddq(vddq), .a(a), .q(q), .q_valid(q_valid),
        .busy(busy), .pgm_err(pgm_err), .rd_err(rd_err), .blown_cnt(blown_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: fuse contents, blown count, LFSR and expected pins.
    logic [W-1:0] m_fuse [NW];
    logic [15:0]  m_lfsr;
    logic [W-1:0] exp_q;
    logic         exp_qv, exp_busy, exp_perr, exp_rerr;
    int           exp_cnt;
    logic         chk_en = 1'b0;
    int           total = 0;
    int           bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q",         32'(q),         32'(exp_q));
            chk("q_valid",   32'(q_valid),   32'(exp_qv));
            chk("busy",      32'(busy),      32'(exp_busy));
            chk("pgm_err",   32'(pgm_err),   32'(exp_perr));
            chk("rd_err",    32'(rd_err),    32'(exp_rerr));
            chk("blown_cnt", 32'(blown_cnt), 32'(exp_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        csb = 1'b1; strobe = 1'b0; load = 1'b0; pgenb = 1'b1; vddq = 1'b0;
    endtask

    task automatic set_rd();
        csb = 1'b0; vddq = 1'b0; pgenb = 1'b1; load = 1'b1;
    endtask

    task automatic set_pgm();
        csb = 1'b0; vddq = 1'b1; pgenb = 1'b0; load = 1'b0;
    endtask

    task automatic clear_exp();
        exp_q = '0; exp_qv = 1'b0; exp_busy = 1'b0; exp_perr = 1'b0; exp_rerr = 1'b0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        clear_exp();
        rst = 1'b0;
        tick();
    endtask

    // Program pulse with strobe sampled high for 'hi' cycles.
    task automatic pgm(input int word, input int bitn, input int hi);
        set_pgm();
        a = {3'(bitn), 7'(word)};
        strobe = 1'b1;
        tick();
        exp_busy = 1'b1;
        repeat (hi - 1) tick();
        strobe = 1'b0;
        tick();
        exp_busy = 1'b0;
        if (word >= NW || hi < PMIN) begin
            exp_perr = 1'b1;
        end else if (!m_fuse[word][bitn]) begin
            m_fuse[word][bitn] = 1'b1;
            exp_cnt++;
        end
        set_idle();
        tick();
    endtask

    // Program pulse where pgenb rises while strobe is still high.
    task automatic pgm_abort(input int word, input int bitn, input int drop);
        set_pgm();
        a = {3'(bitn), 7'(word)};
        strobe = 1'b1;
        tick();
        exp_busy = 1'b1;
        repeat (drop - 1) tick();
        pgenb = 1'b1;
        tick();
        exp_busy = 1'b0;
        exp_perr = 1'b1;
        strobe = 1'b0;
        tick();
        set_idle();
        tick();
    endtask

    // Read; 'noisy' drops the mode and re-toggles strobe while busy.
    task automatic rd(input int word, input bit noisy);
        set_rd();
        a = {3'd0, 7'(word)};
        strobe = 1'b1;
        tick();
        exp_busy = 1'b1;
        strobe = 1'b0;
        if (noisy) csb = 1'b1;
        repeat (RL - 1) begin
            tick();
            if (noisy) strobe = ~strobe;
        end
        tick();
        exp_busy = 1'b0;
        exp_qv   = 1'b1;
        if (word < NW) begin
            exp_q = m_fuse[word];
        end else begin
            exp_q    = '0;
            exp_rerr = 1'b1;
        end
        tick();
        exp_qv = 1'b0;
        set_idle();
        tick();
    endtask

    task automatic bad_strobe();
        set_idle();
        strobe = 1'b1;
        tick();
        exp_q    = m_lfsr[W-1:0];
        exp_rerr = 1'b1;
        m_lfsr   = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        strobe = 1'b0;
        tick();
    endtask

    task automatic rd_reset(input int word);
        set_rd();
        a = {3'd0, 7'(word)};
        strobe = 1'b1;
        tick();
        exp_busy = 1'b1;
        strobe = 1'b0;
        rst = 1'b1;
        tick();
        clear_exp();
        rst = 1'b0;
        set_idle();
        repeat (RL + 2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < NW; n++) m_fuse[n] = IMG[n*W +: W];
        exp_cnt = 0;
        clear_exp();
        set_idle();
        a   = '0;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_errs", 32'({pgm_err, rd_err, q_valid}), 32'h0);
        chk("rst_blown", 32'(blown_cnt), 32'h0);

        rd(0, 1'b0);
        chk("lit_rd_w0", 32'(q), 32'h10);
        chk("lit_rd_err0", 32'(rd_err), 32'h0);
        rd(5, 1'b1);
        chk("lit_rd_w5_noisy", 32'(q), 32'hA5);
        chk("lit_noisy_rd_err", 32'(rd_err), 32'h0);

        pgm(2, 7, 4);
        chk("lit_blown_1", 32'(blown_cnt), 32'd1);
        rd(2, 1'b0);
        chk("lit_rd_w2", 32'(q), 32'h80);
        pgm(3, 0, 4);
        pgm(5, 1, 7);
        chk("lit_blown_3", 32'(blown_cnt), 32'd3);

        pgm(2, 7, 3);
        chk("lit_short_err", 32'(pgm_err), 32'h1);
        pgm(2, 7, 5);
        chk("lit_reblow_cnt", 32'(blown_cnt), 32'd3);

        do_reset();
        pgm(5, 0, 4);
        chk("lit_reblow_img_err", 32'(pgm_err), 32'h0);
        pgm_abort(4, 3, 2);
        chk("lit_abort_err", 32'(pgm_err), 32'h1);
        pgm_abort(4, 2, 5);
        rd(4, 1'b0);
        chk("lit_abort_w4", 32'(q), 32'h0);
        chk("lit_abort_cnt", 32'(blown_cnt), 32'd3);

        do_reset();
        pgm(110, 0, 5);
        chk("lit_oob_pgm_err", 32'(pgm_err), 32'h1);

        do_reset();
        bad_strobe();
        chk("lit_lfsr_1", 32'(q), 32'hE1);
        chk("lit_lfsr_err", 32'(rd_err), 32'h1);
        bad_strobe();
        chk("lit_lfsr_2", 32'(q), 32'h70);

        do_reset();
        rd(0, 1'b0);
        rd(120, 1'b0);
        chk("lit_oob_rd_q", 32'(q), 32'h0);
        chk("lit_oob_rd_err", 32'(rd_err), 32'h1);
        rd(2, 1'b0);
        rd_reset(2);
        chk("lit_rst_rd_q", 32'(q), 32'h0);
        chk("lit_rst_rd_err", 32'(rd_err), 32'h0);
        chk("lit_rst_rd_cnt", 32'(blown_cnt), 32'd3);
        rd(3, 1'b0);
        chk("lit_rd_w3", 32'(q), 32'h01);
        rd(5, 1'b0);
        chk("lit_rd_w5", 32'(q), 32'hA7);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
